hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed forwarding-unit and hazard-detection pair in the 5-stage MIPS pipeline.
- Tracks every in-flight register write from ID through WB in a DEPTH-entry shift register. Each write carries a per-instruction result latency.
- Drives operand forward selects into ID and the ID/EX bubble (stall) for arbitrary producer latencies: ALU, load, or multi-cycle units.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// In-flight register-write scoreboard: drives ID operand forward selects and the
// ID/EX bubble for producers of arbitrary latency, and counts stall cycles.

module hazard_lookup #(
    parameter int DEPTH = 3,
    parameter int RW    = 5,
    parameter int LAT_W = 2,
    parameter int SW    = 2
) (
    input  logic [DEPTH:1]            vld,
    input  logic [DEPTH:1][RW-1:0]    rw,
    input  logic [DEPTH:1][LAT_W-1:0] lat,
    input  logic [RW-1:0]             src,
    input  logic                      use_src,
    output logic [SW-1:0]             sel,
    output logic                      haz
);
    // Walk oldest to youngest so the youngest match has the last word.
    always_comb begin
        sel = '0;
        haz = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (vld[k] && rw[k] == src) begin
                if (k >= int'(lat[k])) begin
                    sel = SW'(k);
                    haz = 1'b0;
                end else begin
                    sel = '0;
                    haz = 1'b1;
                end
            end
        end
        if (!use_src || src == '0) begin
            sel = '0;
            haz = 1'b0;
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int RW    = 5,
    parameter int LAT_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [RW-1:0]              id_rs,
    input  logic [RW-1:0]              id_rt,
    input  logic                       id_use_rs,
    input  logic                       id_use_rt,
    input  logic                       id_regwr,
    input  logic [RW-1:0]              id_rw,
    input  logic [LAT_W-1:0]           id_lat,
    input  logic                       flush,
    input  logic                       hold,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] fwd_a,
    output logic [$clog2(DEPTH+1)-1:0] fwd_b,
    output logic [CNT_W-1:0]           stall_cnt
);
    localparam int SW = $clog2(DEPTH+1);

    logic [DEPTH:1]            vld_pipe;
    logic [DEPTH:1][RW-1:0]    rw_pipe;
    logic [DEPTH:1][LAT_W-1:0] lat_pipe;

    logic [1:0][RW-1:0] src;
    logic [1:0]         use_v;
    logic [1:0][SW-1:0] sel;
    logic [1:0]         haz;
    logic               new_entry;
    logic [LAT_W-1:0]   lat_in;

    assign src   = {id_rt, id_rs};
    assign use_v = {id_use_rt, id_use_rs};

    genvar g;
    for (g = 0; g < 2; g++) begin : g_src
        hazard_lookup #(.DEPTH(DEPTH), .RW(RW), .LAT_W(LAT_W), .SW(SW)) u_lk (
            .vld     (vld_pipe),
            .rw      (rw_pipe),
            .lat     (lat_pipe),
            .src     (src[g]),
            .use_src (use_v[g]),
            .sel     (sel[g]),
            .haz     (haz[g])
        );
    end

    assign stall     = (|haz) & id_valid & ~flush;
    assign fwd_a     = sel[0];
    assign fwd_b     = sel[1];
    assign new_entry = id_valid & id_regwr & ~flush & (id_rw != '0);
    // A latency of 0 would mean "forwardable before EX", which cannot happen.
    assign lat_in    = (id_lat == '0) ? LAT_W'(1) : id_lat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            rw_pipe   <= '0;
            lat_pipe  <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                vld_pipe[k] <= vld_pipe[k-1];
                rw_pipe[k]  <= rw_pipe[k-1];
                lat_pipe[k] <= lat_pipe[k-1];
            end
            vld_pipe[1] <= new_entry & ~stall;
            rw_pipe[1]  <= id_rw;
            lat_pipe[1] <= lat_in;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic checked
// against a queue-of-producers model that tracks each write's age since ID.

module tb_hazard_scoreboard;
    localparam int DEPTH = 3;
    localparam int RW    = 5;
    localparam int LAT_W = 2;
    localparam int CNT_W = 16;
    localparam int SW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             id_valid, id_use_rs, id_use_rt, id_regwr, flush, hold;
    logic [RW-1:0]    id_rs, id_rt, id_rw;
    logic [LAT_W-1:0] id_lat;
    logic             stall, stall2;
    logic [SW-1:0]    fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       stall_cnt2;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(DEPTH), .RW(RW), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwr(id_regwr),
        .id_rw(id_rw), .id_lat(id_lat), .flush(flush), .hold(hold),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.DEPTH(DEPTH), .RW(RW), .LAT_W(LAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwr(id_regwr),
        .id_rw(id_rw), .id_lat(id_lat), .flush(flush), .hold(hold),
        .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        int rw;
        int lat;
        int age;
    } inflight_t;

    inflight_t q[$];
    int exp_cnt, exp_cnt2;
    int n_total, n_bad;

    // Youngest producer of r decides; it is usable once its age reaches its latency.
    function automatic void lookup(input int r, input bit u, output int sel, output bit haz);
        int best = -1;
        sel = 0;
        haz = 1'b0;
        if (!u || r == 0) return;
        foreach (q[i])
            if (q[i].rw == r && (best < 0 || q[i].age < q[best].age)) best = i;
        if (best >= 0) begin
            if (q[best].age >= q[best].lat) sel = q[best].age;
            else haz = 1'b1;
        end
    endfunction

    function automatic void model(output bit s, output int fa, output int fb);
        bit ha, hb;
        lookup(int'(id_rs), id_use_rs, fa, ha);
        lookup(int'(id_rt), id_use_rt, fb, hb);
        s = (ha || hb) && id_valid && !flush;
    endfunction

    task automatic tick();
        bit s;
        int fa, fb;
        model(s, fa, fb);
        @(posedge clk);
        if (!hold) begin
            foreach (q[i]) q[i].age++;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].age > DEPTH) q.delete(i);
            if (!s && id_valid && id_regwr && !flush && id_rw != 0)
                q.push_back('{int'(id_rw), (id_lat == 0) ? 1 : int'(id_lat), 1});
            if (s) begin
                if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_regwr = 0; id_rw = 0; id_lat = 0; flush = 0; hold = 0;
    endtask

    task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                         input bit wr, input int rw, input int lat);
        id_valid = 1; id_rs = RW'(rs); id_rt = RW'(rt); id_use_rs = urs; id_use_rt = urt;
        id_regwr = wr; id_rw = RW'(rw); id_lat = LAT_W'(lat); flush = 0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 0;
        q.delete();
        exp_cnt = 0;
        exp_cnt2 = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        idle();
        issue(3, 4, 1, 1, 1, 6, 2);
        #1;
        n_total++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_total++; if (fwd_a !== '0 || fwd_b !== '0) begin n_bad++; $display("FAIL reset_fwd: got a=%0d b=%0d want 0 0", fwd_a, fwd_b); end
        n_total++; if (stall_cnt !== '0 || stall_cnt2 !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, stall_cnt2); end
        apply_reset();
    endtask

    task automatic test_alu_chain();
        apply_reset();
        issue(0, 0, 0, 0, 1, 3, 2);
        #1;
        n_total++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_producer_stall: got %0b want 0", stall); end
        tick();
        issue(3, 0, 1, 0, 1, 6, 2);
        #1;
        n_total++; if (stall !== 1'b1 || fwd_a !== 2'd0) begin n_bad++; $display("FAIL alu_c1: got stall=%0b fwd_a=%0d want 1 0", stall, fwd_a); end
        tick();
        #1;
        n_total++; if (stall !== 1'b0 || fwd_a !== 2'd2) begin n_bad++; $display("FAIL alu_c2: got stall=%0b fwd_a=%0d want 0 2", stall, fwd_a); end
        n_total++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL alu_cnt: got %0d want 1", stall_cnt); end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        apply_reset();
        issue(0, 0, 0, 0, 1, 5, 3);
        tick();
        issue(0, 5, 0, 1, 1, 7, 2);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_total++; if (stall !== 1'b1 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL load_stall%0d: got stall=%0b fwd_b=%0d want 1 0", c, stall, fwd_b); end
            tick();
        end
        #1;
        n_total++; if (stall !== 1'b0 || fwd_b !== 2'd3) begin n_bad++; $display("FAIL load_fwd: got stall=%0b fwd_b=%0d want 0 3", stall, fwd_b); end
        n_total++; if (stall_cnt !== 16'd2 || stall_cnt2 !== 2'd2) begin n_bad++; $display("FAIL load_cnt: got %0d/%0d want 2/2", stall_cnt, stall_cnt2); end
        tick();
        drain();
    endtask

    task automatic test_youngest();
        apply_reset();
        issue(0, 0, 0, 0, 1, 4, 2);
        tick();
        issue(0, 0, 0, 0, 1, 4, 2);
        tick();
        idle();
        tick();
        issue(4, 4, 1, 1, 0, 0, 2);
        #1;
        n_total++; if (stall !== 1'b0 || fwd_a !== 2'd2 || fwd_b !== 2'd2) begin n_bad++; $display("FAIL youngest: got stall=%0b a=%0d b=%0d want 0 2 2", stall, fwd_a, fwd_b); end
        tick();
        drain();
    endtask

    task automatic test_r0_flush();
        apply_reset();
        issue(0, 0, 0, 0, 1, 0, 2);
        tick();
        issue(0, 0, 1, 1, 1, 9, 2);
        #1;
        n_total++; if (stall !== 1'b0 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL r0: got stall=%0b a=%0d b=%0d want 0 0 0", stall, fwd_a, fwd_b); end
        tick();
        issue(0, 0, 0, 0, 1, 7, 3);
        tick();
        issue(7, 0, 1, 0, 1, 8, 1);
        flush = 1;
        #1;
        n_total++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0b want 0", stall); end
        tick();
        issue(8, 7, 1, 1, 0, 0, 1);
        #1;
        n_total++; if (fwd_a !== 2'd0 || stall !== 1'b1) begin n_bad++; $display("FAIL flush_slot1: got a=%0d stall=%0b want 0 1", fwd_a, stall); end
        n_total++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL flush_cnt: got %0d want 0", stall_cnt); end
        tick();
        drain();
    endtask

    task automatic test_hold();
        apply_reset();
        issue(0, 0, 0, 0, 1, 9, 2);
        tick();
        issue(9, 0, 1, 0, 1, 10, 2);
        hold = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++; if (stall !== 1'b1 || fwd_a !== 2'd0 || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL hold%0d: got stall=%0b a=%0d cnt=%0d want 1 0 0", c, stall, fwd_a, stall_cnt); end
            tick();
        end
        idle();
        tick();
        issue(9, 0, 1, 0, 0, 0, 2);
        #1;
        n_total++; if (stall !== 1'b0 || fwd_a !== 2'd2 || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL hold_release: got stall=%0b a=%0d cnt=%0d want 0 2 0", stall, fwd_a, stall_cnt); end
        tick();
        drain();
    endtask

    task automatic test_reset_sat();
        apply_reset();
        issue(0, 0, 0, 0, 1, 5, 3);
        tick();
        issue(5, 0, 1, 0, 1, 5, 3);
        #1;
        n_total++; if (stall !== 1'b1) begin n_bad++; $display("FAIL pre_reset_stall: got %0b want 1", stall); end
        tick();
        #3;
        rst = 0;
        q.delete();
        exp_cnt = 0;
        exp_cnt2 = 0;
        #1;
        n_total++; if (stall !== 1'b0 || fwd_a !== 2'd0) begin n_bad++; $display("FAIL async_reset: got stall=%0b a=%0d want 0 0", stall, fwd_a); end
        n_total++; if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin n_bad++; $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", stall_cnt, stall_cnt2); end
        @(negedge clk);
        rst = 1;
        #1;
        n_total++; if (stall !== 1'b0) begin n_bad++; $display("FAIL post_reset_stall: got %0b want 0", stall); end
        issue(0, 0, 0, 0, 1, 5, 3);
        tick();
        issue(5, 0, 1, 0, 1, 5, 3);
        repeat (8) tick();
        #1;
        n_total++; if (stall_cnt !== 16'd6) begin n_bad++; $display("FAIL sat_cnt16: got %0d want 6", stall_cnt); end
        n_total++; if (stall_cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_cnt2: got %0d want 3", stall_cnt2); end
        drain();
    endtask

    task automatic test_random();
        bit s;
        int fa, fb;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            id_valid  = ($urandom_range(0, 7) != 0);
            id_rs     = RW'($urandom_range(0, 5));
            id_rt     = RW'($urandom_range(0, 5));
            id_use_rs = $urandom_range(0, 1);
            id_use_rt = $urandom_range(0, 1);
            id_regwr  = ($urandom_range(0, 3) != 0);
            id_rw     = RW'($urandom_range(0, 5));
            id_lat    = LAT_W'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 9) == 0);
            hold      = ($urandom_range(0, 9) == 0);
            #1;
            model(s, fa, fb);
            n_total++; if (stall !== s || stall2 !== s) begin n_bad++; $display("FAIL rnd_stall c%0d: got %0b/%0b want %0b", c, stall, stall2, s); end
            n_total++; if (fwd_a !== SW'(fa) || fwd_a2 !== SW'(fa)) begin n_bad++; $display("FAIL rnd_fwd_a c%0d: got %0d want %0d", c, fwd_a, fa); end
            n_total++; if (fwd_b !== SW'(fb) || fwd_b2 !== SW'(fb)) begin n_bad++; $display("FAIL rnd_fwd_b c%0d: got %0d want %0d", c, fwd_b, fb); end
            n_total++; if (stall_cnt !== CNT_W'(exp_cnt) || stall_cnt2 !== 2'(exp_cnt2)) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, stall_cnt2, exp_cnt, exp_cnt2); end
            tick();
        end
        drain();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest();
        test_r0_flush();
        test_hold();
        test_reset_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
